sad_min_tracker: RTL

//   Downstream of the SAD adder tree. Consumes one per-row partial SAD per valid cycle.

---
 rtl/sad_min_tracker_pkg.sv | 39 +++
 rtl/sad_min_tracker_if.sv | 27 ++
 rtl/sad_min_tracker_row_acc.sv | 42 ++++
 rtl/sad_min_tracker.sv | 112 +++++++++++
 4 files changed

// File: rtl/sad_min_tracker_pkg.sv
// me_pkg: shared constants and types for the SAD minimum tracker.
//   BIT_WIDTH/ROWS/SEARCH_R/ZERO_BIAS : default configuration
//   ACC_W : candidate SAD width (cannot overflow for ROWS partials)
//   MV_W  : signed motion-vector component width
//   state_t : tracker FSM states; mv_t : motion vector pair
//   apply_zero_bias : max(sad - ZERO_BIAS, 0), used only when the
//     SAD_ZERO_BIAS_EN macro is defined
package me_pkg;

  localparam int BIT_WIDTH = 14;
  localparam int ROWS      = 16;
  localparam int SEARCH_R  = 8;
  localparam int ZERO_BIAS = 64;

  localparam int ACC_W = BIT_WIDTH + $clog2(ROWS);
  localparam int MV_W  = $clog2(2 * SEARCH_R) + 1;
  localparam int CNT_W = $clog2(2 * SEARCH_R);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  typedef struct packed {
    logic signed [MV_W-1:0] mvx;
    logic signed [MV_W-1:0] mvy;
  } mv_t;

  // Saturating subtract of the zero-vector credit.
  function automatic logic [ACC_W-1:0] apply_zero_bias(input logic [ACC_W-1:0] sad);
    if (sad > ACC_W'(ZERO_BIAS)) begin
      return sad - ACC_W'(ZERO_BIAS);
    end
    return '0;
  endfunction

endpackage

// File: rtl/sad_min_tracker_if.sv
// sad_min_tracker_if: handshake/result bundle between the motion-estimation
// control stage (master) and the SAD minimum tracker (slave).
//   start, in_valid, partial_sad : master -> tracker
//   busy, done, best_sad, best_mvx, best_mvy : tracker -> master
interface sad_min_tracker_if;
  import me_pkg::*;

  logic                   start;
  logic                   in_valid;
  logic [BIT_WIDTH-1:0]   partial_sad;
  logic                   busy;
  logic                   done;
  logic [ACC_W-1:0]       best_sad;
  logic signed [MV_W-1:0] best_mvx;
  logic signed [MV_W-1:0] best_mvy;

  modport master (
    output start, in_valid, partial_sad,
    input  busy, done, best_sad, best_mvx, best_mvy
  );

  modport slave (
    input  start, in_valid, partial_sad,
    output busy, done, best_sad, best_mvx, best_mvy
  );

endinterface

// File: rtl/sad_min_tracker_row_acc.sv
// sad_row_accumulator: sums ROWS per-row partial SADs into one candidate SAD.
//   clk, srst    : clock, synchronous active-high reset
//   clear        : drop any partial accumulation (new/aborted search)
//   en           : partial_sad accepted this cycle
//   partial_sad  : row partial SAD (zero-extended into the accumulator)
//   sad_c        : acc + partial_sad, the same-cycle candidate total
//   close        : en on the last row of a candidate; sad_c is final then
module sad_row_accumulator
  import me_pkg::*;
(
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 clear,
  input  logic                 en,
  input  logic [BIT_WIDTH-1:0] partial_sad,
  output logic [ACC_W-1:0]     sad_c,
  output logic                 close
);

  logic [ACC_W-1:0] acc_reg;
  logic [ROW_W-1:0] row_cnt_reg;

  // Combinational total lets the candidate close without an extra bubble.
  assign sad_c = acc_reg + ACC_W'(partial_sad);
  assign close = en && (row_cnt_reg == ROW_W'(ROWS - 1));

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      acc_reg     <= '0;
      row_cnt_reg <= '0;
    end else if (en) begin
      if (close) begin
        acc_reg     <= '0;
        row_cnt_reg <= '0;
      end else begin
        acc_reg     <= sad_c;
        row_cnt_reg <= row_cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sad_min_tracker.sv
// sad_min_tracker: tracks the minimum candidate SAD and its motion vector over
// a raster scan of (2*SEARCH_R)^2 candidates, ROWS partial SADs each.
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high (wins over start)
//   bus  : sad_min_tracker_if.slave
//          start/in_valid/partial_sad in; busy/done/best_sad/best_mvx/best_mvy out
// Optional feature: define SAD_ZERO_BIAS_EN to credit the (0,0) candidate by
// ZERO_BIAS (saturating at 0) before it is compared and stored.
module sad_min_tracker
  import me_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  sad_min_tracker_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(2 * SEARCH_R - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(SEARCH_R);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] x_cnt_reg, y_cnt_reg;
  logic [ACC_W-1:0] best_sad_reg;
  mv_t              best_mv_reg;

  logic             accept;
  logic [ACC_W-1:0] sad_c;
  logic             close;
  logic             last_cand;
  logic [ACC_W-1:0] cand_val;
  mv_t              cur_mv;
  logic [MV_W-1:0]  mvx_raw, mvy_raw;

  // A start cycle never contributes data, whether it begins or aborts a search.
  assign accept = (state_reg == RUN) && bus.in_valid && !bus.start;

  sad_row_accumulator u_row_acc (
    .clk         (clk),
    .srst        (rst),
    .clear       (bus.start),
    .en          (accept),
    .partial_sad (bus.partial_sad),
    .sad_c       (sad_c),
    .close       (close)
  );

  assign mvx_raw   = {1'b0, x_cnt_reg} - MV_W'(SEARCH_R);
  assign mvy_raw   = {1'b0, y_cnt_reg} - MV_W'(SEARCH_R);
  assign cur_mv    = '{mvx: mvx_raw, mvy: mvy_raw};
  assign last_cand = (x_cnt_reg == CNT_MAX) && (y_cnt_reg == CNT_MAX);

`ifdef SAD_ZERO_BIAS_EN
  assign cand_val = ((x_cnt_reg == CNT_ZERO) && (y_cnt_reg == CNT_ZERO))
                  ? apply_zero_bias(sad_c) : sad_c;
`else
  assign cand_val = sad_c;
`endif

  always_comb begin
    state_next = state_reg;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) state_next = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (!bus.start && close && last_cand) state_next = FINISH;
      end
      FINISH: begin
        bus.done   = 1'b1;
        state_next = bus.start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      x_cnt_reg    <= '0;
      y_cnt_reg    <= '0;
      best_sad_reg <= '1;
      best_mv_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (bus.start) begin
        x_cnt_reg    <= '0;
        y_cnt_reg    <= '0;
        best_sad_reg <= '1;
        best_mv_reg  <= '0;
      end else if (close) begin
        // Strict compare: on a tie the earlier candidate in raster order stays.
        if (cand_val < best_sad_reg) begin
          best_sad_reg <= cand_val;
          best_mv_reg  <= cur_mv;
        end
        if (x_cnt_reg == CNT_MAX) begin
          x_cnt_reg <= '0;
          y_cnt_reg <= last_cand ? '0 : y_cnt_reg + 1'b1;
        end else begin
          x_cnt_reg <= x_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign bus.best_sad = best_sad_reg;
  assign bus.best_mvx = best_mv_reg.mvx;
  assign bus.best_mvy = best_mv_reg.mvy;

endmodule
